// File: rtl/bit_extract_ctrl.sv
// ---------------------------------------------------------------------------
// bit_extract_ctrl
//   Read-side controller for a 32-bit word FIFO. It pops words into a 64-bit
//   left-aligned bit buffer and serves variable-length field requests
//   (1..15 bits), MSB-first. The next bit to hand out is always the top bit of
//   the buffer. Only the top 'count' bits are valid; all bits below them are
//   kept at zero, so that a new word can be OR-ed in just below them.
//
// Ports
//   Clk           clock, all state on the rising edge
//   RstN          asynchronous reset, active low
//   fifo_data     FIFO read data (valid while fifo_empty_n=1)
//   fifo_empty_n  FIFO holds at least one word
//   fifo_rd_n     FIFO pop, active low, combinational (FIFO pops at the edge)
//   flush         synchronous discard of all buffered bits
//   reqin         field request valid
//   reqlen        requested field length (0 is ignored)
//   pushout       one-cycle pulse per served request
//   lenout        length of the delivered field
//   dataout       delivered field, right-justified, upper bits zero
//   bits_avail    number of bits currently held in the buffer
//
// Request handshake: the requester raises reqin with reqlen and holds both
// stable until it sees pushout=1. A request is accepted on an edge where the
// buffer already holds at least reqlen bits and no flush is active; pushout,
// lenout and dataout present the field in the cycle after that edge. reqin
// still high during the pushout cycle counts as the next request, so one
// field per cycle can be streamed.
// ---------------------------------------------------------------------------
module bit_extract_ctrl #(
  parameter int DW = 32,
  parameter int LW = 4,
  parameter int CW = 7
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic [DW-1:0]        fifo_data,
  input  logic                 fifo_empty_n,
  output logic                 fifo_rd_n,
  input  logic                 flush,
  input  logic                 reqin,
  input  logic [LW-1:0]        reqlen,
  output logic                 pushout,
  output logic [LW-1:0]        lenout,
  output logic [(2**LW)-2:0]   dataout,
  output logic [CW-1:0]        bits_avail
);

  localparam int FW = (2**LW) - 1;   // widest field
  localparam int BW = 2 * DW;        // buffer width

  logic [BW-1:0] buf_q;
  logic [CW-1:0] count_q;

  logic          take;
  logic          load;
  logic [CW-1:0] take_len;
  logic [CW-1:0] remain;
  logic [BW-1:0] word_ext;
  logic [BW-1:0] buf_next;
  logic [CW-1:0] count_next;
  logic [FW-1:0] top_bits;
  logic [FW-1:0] field;

  // Accept is judged on the current count only; a word loaded on the same
  // edge does not help this request.
  assign take = reqin && (reqlen != '0) && (count_q >= CW'(reqlen)) && !flush;
  // Loading only at count<=DW guarantees the buffer never overflows.
  assign load = fifo_empty_n && (count_q <= CW'(DW)) && !flush;

  // Held low-active pop is forced inactive while reset is asserted.
  assign fifo_rd_n = ~(load & RstN);

  always_comb begin
    take_len   = take ? CW'(reqlen) : '0;
    remain     = count_q - take_len;
    // New word goes directly below the bits that survive this extraction.
    word_ext   = {fifo_data, {DW{1'b0}}} >> remain;
    buf_next   = (buf_q << take_len) | (load ? word_ext : '0);
    count_next = remain + (load ? CW'(DW) : '0);
    // Top FW bits, shifted down so the requested field is right-justified.
    top_bits   = buf_q[BW-1 -: FW];
    field      = top_bits >> (LW'(FW) - reqlen);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      buf_q   <= '0;
      count_q <= '0;
      pushout <= 1'b0;
      lenout  <= '0;
      dataout <= '0;
    end else if (flush) begin
      buf_q   <= '0;
      count_q <= '0;
      pushout <= 1'b0;
    end else begin
      buf_q   <= buf_next;
      count_q <= count_next;
      pushout <= take;
      if (take) begin
        lenout  <= reqlen;
        dataout <= field;
      end
    end
  end

  assign bits_avail = count_q;

endmodule

// File: tb/tb_bit_extract_ctrl.sv
module tb_bit_extract_ctrl;

  logic        Clk;
  logic        RstN;
  logic [31:0] fifo_data;
  logic        fifo_empty_n;
  logic        fifo_rd_n;
  logic        flush;
  logic        reqin;
  logic [3:0]  reqlen;
  logic        pushout;
  logic [3:0]  lenout;
  logic [14:0] dataout;
  logic [6:0]  bits_avail;

  bit_extract_ctrl dut (
    .Clk          (Clk),
    .RstN         (RstN),
    .fifo_data    (fifo_data),
    .fifo_empty_n (fifo_empty_n),
    .fifo_rd_n    (fifo_rd_n),
    .flush        (flush),
    .reqin        (reqin),
    .reqlen       (reqlen),
    .pushout      (pushout),
    .lenout       (lenout),
    .dataout      (dataout),
    .bits_avail   (bits_avail)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- FIFO model ----------------
  logic [31:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_pulses = 0;
  logic do_pop;

  assign fifo_empty_n = (wr_ptr != rd_ptr);
  assign fifo_data    = fifo_empty_n ? fmem[rd_ptr[5:0]] : 32'h0;

  always begin
    @(posedge Clk);
    do_pop = !fifo_rd_n;
    #1;
    if (do_pop) begin
      rd_ptr = rd_ptr + 1;
      rd_pulses = rd_pulses + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];   // {len, data}
  int checks = 0;
  int failures = 0;
  int pcount = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (RstN && pushout) begin
      pcount++;
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_push actual=len%0d/0x%0h expected=none", lenout, dataout);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          if ({lenout, dataout} !== e) begin
            failures++;
            $display("FAIL field actual=len%0d/0x%0h expected=len%0d/0x%0h",
                     lenout, dataout, e[18:15], e[14:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [31:0] w);
    fmem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_push(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk);
      #1;
      n++;
      if (pushout) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=no_pushout expected=pushout");
    end
  endtask

  task automatic issue(input logic [3:0] len, input logic [14:0] data);
    int n;
    bit ok;
    exp_q.push_back({len, data});
    reqin  = 1'b1;
    reqlen = len;
    wait_push(n, ok);
    reqin  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit ok;
    int pc0;
    int rp0;
    int gaps;

    RstN = 1'b0; flush = 1'b0; reqin = 1'b0; reqlen = 4'd0;
    cycles(3);
    RstN = 1'b1;
    cycles(1);

    // T1: reset in the middle of a stream
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
    push_word(32'h11111111);
    push_word(32'h22222222);
    reqin = 1'b1; reqlen = 4'd3;
    cycles(5);
    check("t1_pushout_before_reset", 32'(pushout), 32'd1);
    #2;
    RstN = 1'b0;
    #1;
    check("t1_pushout_in_reset", 32'(pushout), 32'd0);
    check("t1_bits_avail_in_reset", 32'(bits_avail), 32'd0);
    check("t1_rd_n_in_reset", 32'(fifo_rd_n), 32'd1);
    check("t1_dataout_in_reset", 32'(dataout), 32'd0);
    check("t1_lenout_in_reset", 32'(lenout), 32'd0);
    reqin = 1'b0;
    wr_ptr = rd_ptr;   // drop leftover words
    cycles(2);
    RstN = 1'b1;
    pc0 = pcount;
    reqin = 1'b1; reqlen = 4'd3;
    cycles(8);
    reqin = 1'b0;
    check("t1_no_push_after_reset", 32'(pcount - pc0), 32'd0);
    mon_en = 1'b1;

    // T2: basic extraction
    push_word(32'hA5A50F0F);
    issue(4'd4, 15'h000A);
    issue(4'd15, 15'h2D28);
    check("t2_bits_avail", 32'(bits_avail), 32'd13);
    do_flush();

    // T3: field spanning two words
    rp0 = rd_pulses;
    push_word(32'h00000003);
    push_word(32'h80000000);
    issue(4'd15, 15'h0000);
    issue(4'd15, 15'h0000);
    issue(4'd4, 15'h000E);
    cycles(3);
    check("t3_rd_pulses", 32'(rd_pulses - rp0), 32'd2);
    check("t3_bits_avail", 32'(bits_avail), 32'd30);
    do_flush();

    // T4: starvation, then data arrives
    pc0 = pcount;
    reqin = 1'b1; reqlen = 4'd8;
    cycles(10);
    check("t4_starved", 32'(pcount - pc0), 32'd0);
    exp_q.push_back({4'd8, 15'h00FF});
    push_word(32'hFF000000);
    wait_push(n, ok);
    reqin = 1'b0;
    if (ok) check("t4_latency", 32'(n), 32'd2);
    do_flush();

    // T5: one-bit streaming, then zero-length requests
    pc0 = pcount;
    for (int i = 0; i < 64; i++)
      exp_q.push_back({4'd1, ((i % 2) == 0) ? 15'd1 : 15'd0});
    push_word(32'hAAAAAAAA);
    push_word(32'hAAAAAAAA);
    reqin = 1'b1; reqlen = 4'd1;
    wait_push(n, ok);
    gaps = 0;
    for (int i = 0; i < 63; i++) begin
      cycles(1);
      if (!pushout) gaps++;
    end
    check("t5_gaps", 32'(gaps), 32'd0);
    reqlen = 4'd0;
    push_word(32'hAAAAAAAA);
    cycles(6);
    check("t5_push_count", 32'(pcount - pc0), 32'd64);
    check("t5_bits_avail", 32'(bits_avail), 32'd32);
    reqin = 1'b0;
    do_flush();

    // T6: flush mid-stream
    push_word(32'h12345678);
    issue(4'd5, 15'h0002);
    check("t6_bits_before_flush", 32'(bits_avail), 32'd27);
    flush = 1'b1;
    cycles(1);
    check("t6_bits_after_flush", 32'(bits_avail), 32'd0);
    check("t6_no_push_on_flush", 32'(pushout), 32'd0);
    flush = 1'b0;
    push_word(32'hF0000000);
    issue(4'd4, 15'h000F);

    cycles(4);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
